// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent 50%-duty clock dividers with graceful stop.
// Optional macro CLK_DIV_STEP_EN adds push-button single-step on channel 0.
module clk_div_multi #(
    parameter int NCH   = 2,
    parameter int CNT_W = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] div_half,
    input  logic                 step_mode,
    input  logic                 step,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_STEP_HI,
        ST_STEP_LO
    } state_t;

    state_t           r_state    [NCH];
    state_t           w_state_nx [NCH];
    logic [CNT_W-1:0] r_cnt      [NCH];
    logic [CNT_W-1:0] w_cnt_nx   [NCH];
    logic [NCH-1:0]   r_clk;
    logic [NCH-1:0]   w_clk_nx;
    logic [NCH-1:0]   r_tick;
    logic [NCH-1:0]   w_tick_nx;
    logic [NCH-1:0]   w_run;
    logic             w_step_rise;
    logic             w_step_mode;

`ifdef CLK_DIV_STEP_EN
    logic r_step_s1;
    logic r_step_s2;
    logic r_step_d;

    // Two-flop synchroniser for the button, plus a delay flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
            r_step_d  <= 1'b0;
        end else begin
            r_step_s1 <= step;
            r_step_s2 <= r_step_s1;
            r_step_d  <= r_step_s2;
        end
    end

    assign w_step_rise = r_step_s2 & ~r_step_d;
    assign w_step_mode = step_mode;
`else
    logic w_step_unused;

    assign w_step_rise   = 1'b0;
    assign w_step_mode   = 1'b0;
    assign w_step_unused = step ^ step_mode;
`endif

    // Effective run request; step mode takes channel 0 away from en[0]
    always_comb begin
        w_run    = en;
        w_run[0] = en[0] & ~w_step_mode;
    end

    // Per-channel next-state, counter and divided-clock logic
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_clk_nx[i]   = r_clk[i];
            unique case (r_state[i])
                ST_IDLE: begin
                    if (i == 0 && w_step_mode) begin
                        if (w_step_rise) begin
                            w_clk_nx[i]   = 1'b1;
                            w_cnt_nx[i]   = div_half[i*CNT_W +: CNT_W];
                            w_state_nx[i] = ST_STEP_HI;
                        end
                    end else if (w_run[i]) begin
                        w_clk_nx[i]   = 1'b0;
                        w_cnt_nx[i]   = div_half[i*CNT_W +: CNT_W];
                        w_state_nx[i] = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!w_run[i]) begin
                        if (!r_clk[i]) begin
                            w_state_nx[i] = ST_IDLE;
                        end else if (r_cnt[i] == '0) begin
                            // High phase ends right now: fall and stop
                            w_clk_nx[i]   = 1'b0;
                            w_state_nx[i] = ST_IDLE;
                        end else begin
                            w_cnt_nx[i]   = r_cnt[i] - CNT_W'(1);
                            w_state_nx[i] = ST_DRAIN;
                        end
                    end else if (r_cnt[i] == '0) begin
                        w_clk_nx[i] = ~r_clk[i];
                        w_cnt_nx[i] = div_half[i*CNT_W +: CNT_W];
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt[i] == '0) begin
                        w_clk_nx[i] = 1'b0;
                        if (w_run[i]) begin
                            w_cnt_nx[i]   = div_half[i*CNT_W +: CNT_W];
                            w_state_nx[i] = ST_RUN;
                        end else begin
                            w_state_nx[i] = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                ST_STEP_HI: begin
                    if (r_cnt[i] == '0) begin
                        w_clk_nx[i]   = 1'b0;
                        w_cnt_nx[i]   = div_half[i*CNT_W +: CNT_W];
                        w_state_nx[i] = ST_STEP_LO;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                ST_STEP_LO: begin
                    if (r_cnt[i] == '0) begin
                        w_state_nx[i] = ST_IDLE;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - CNT_W'(1);
                    end
                end
                default: begin
                    w_clk_nx[i]   = 1'b0;
                    w_state_nx[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Tick marks exactly the edges where the divided clock goes 0->1
    always_comb begin
        w_tick_nx = w_clk_nx & ~r_clk;
    end

    // State, counter and output registers; reset drops outputs at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_clk  <= '0;
            r_tick <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
            r_clk  <= w_clk_nx;
            r_tick <= w_tick_nx;
        end
    end

    // Busy straight from the registered state
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (r_state[i] != ST_IDLE);
        end
    end

    assign clk_out = r_clk;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench for clk_div_multi (NCH=2, CNT_W=26).
// Expected per-edge outputs are queued with the stimulus and popped after each edge.
module tb_clk_div_multi;

    localparam int NCH   = 2;
    localparam int CNT_W = 26;

    logic                 clk;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic [NCH*CNT_W-1:0] div_half;
    logic                 step_mode;
    logic                 step;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       busy;

    logic [CNT_W-1:0] d0;
    logic [CNT_W-1:0] d1;

    assign div_half = {d1, d0};

    clk_div_multi #(
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_half  (div_half),
        .step_mode (step_mode),
        .step      (step),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] co;
        logic [1:0] tk;
        logic [1:0] bz;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    exp_t  m_e;
    string m_t;
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Clock-out / tick of a running channel, p edges after its start edge
    function automatic logic [1:0] run_ct(input int p, input int d);
        logic c;
        logic t;
        c = ((p / (d + 1)) % 2) == 1;
        t = (p > 0) && ((p % (2 * (d + 1))) == d + 1);
        return {c, t};
    endfunction

    task automatic push(input string tag, input logic [1:0] co,
                        input logic [1:0] tk, input logic [1:0] bz);
        exp_t e;
        e.co = co;
        e.tk = tk;
        e.bz = bz;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = '0;
        #1;
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_t = tag_q.pop_front();
            chk({m_t, "_clk"}, 32'(clk_out), 32'(m_e.co));
            chk({m_t, "_tick"}, 32'(tick), 32'(m_e.tk));
            chk({m_t, "_busy"}, 32'(busy), 32'(m_e.bz));
        end
    end

    logic [1:0] r0;
    logic [1:0] r1;
    logic       c;
    logic       t;
    logic       b;

    initial begin
        rst_n     = 1'b0;
        en        = '0;
        d0        = '0;
        d1        = '0;
        step      = 1'b0;
        step_mode = 1'b0;
        #3;
        chk("por_clk", 32'(clk_out), 32'd0);
        chk("por_tick", 32'(tick), 32'd0);
        chk("por_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push("idle", 2'b00, 2'b00, 2'b00);

        // D0=0 (clk/2) and D1=3 (clk/8) started together
        d0 = 26'd0;
        d1 = 26'd3;
        en = 2'b11;
        for (int p = 0; p <= 24; p++) begin
            r0 = run_ct(p, 0);
            r1 = run_ct(p, 3);
            push("s1", {r1[1], r0[1]}, {r1[0], r0[0]}, 2'b11);
        end
        do_reset();

        // D=5, changed to 1 mid high phase
        d0 = 26'd5;
        en = 2'b01;
        for (int p = 0; p <= 24; p++) begin
            if (p == 8) d0 = 26'd1;
            if (p < 12) begin
                r0 = run_ct(p, 5);
            end else begin
                r0[1] = (((p - 12) / 2) % 2) == 1;
                r0[0] = ((p - 12) % 4) == 2;
            end
            push("s2", {1'b0, r0[1]}, {1'b0, r0[0]}, 2'b01);
        end
        do_reset();

        // One-cycle en pulse: busy one cycle, no clock
        d0 = 26'd4;
        en = 2'b01;
        push("pulse", 2'b00, 2'b00, 2'b01);
        en = 2'b00;
        push("pulse", 2'b00, 2'b00, 2'b00);
        push("pulse", 2'b00, 2'b00, 2'b00);

        // D=4, en dropped 2 cycles after the rise: drain then stop
        en = 2'b01;
        for (int p = 0; p <= 11; p++) begin
            if (p == 7) en = 2'b00;
            c = (p >= 5) && (p <= 9);
            t = (p == 5);
            b = (p <= 9);
            push("drain", {1'b0, c}, {1'b0, t}, {1'b0, b});
        end

        // Same, but en re-raised during the drain
        en = 2'b01;
        for (int q = 0; q <= 21; q++) begin
            if (q == 7) en = 2'b00;
            if (q == 9) en = 2'b01;
            c = ((q >= 5) && (q <= 9)) || ((q >= 15) && (q <= 19));
            t = (q == 5) || (q == 15);
            push("rerun", {1'b0, c}, {1'b0, t}, 2'b01);
        end
        do_reset();

        // Async reset in the middle of a high phase
        d0 = 26'd4;
        d1 = 26'd4;
        en = 2'b11;
        for (int p = 0; p <= 5; p++) begin
            r0 = run_ct(p, 4);
            push("pre_rst", {r0[1], r0[1]}, {r0[0], r0[0]}, 2'b11);
        end
        #2;
        rst_n = 1'b0;
        en    = 2'b00;
        #1;
        chk("arst_clk", 32'(clk_out), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) push("post_rst", 2'b00, 2'b00, 2'b00);
        en = 2'b11;
        for (int p = 0; p <= 6; p++) begin
            r0 = run_ct(p, 4);
            push("restart", {r0[1], r0[1]}, {r0[0], r0[0]}, 2'b11);
        end
        do_reset();

`ifdef CLK_DIV_STEP_EN
        // Single step on channel 0, D=2, button held 10 cycles
        d0        = 26'd2;
        step_mode = 1'b1;
        en        = 2'b01;
        for (int k = 0; k < 3; k++) push("st_ign", 2'b00, 2'b00, 2'b00);
        step = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            if (k == 10) step = 1'b0;
            c = (k >= 2) && (k <= 4);
            t = (k == 2);
            b = (k >= 2) && (k <= 7);
            push("step", {1'b0, c}, {1'b0, t}, {1'b0, b});
        end
`else
        // step and step_mode have no effect: channel 0 follows en[0]
        d0        = 26'd2;
        step_mode = 1'b1;
        en        = 2'b01;
        for (int p = 0; p <= 17; p++) begin
            step = p[0];
            r0   = run_ct(p, 2);
            push("nostep", {1'b0, r0[1]}, {1'b0, r0[0]}, 2'b01);
        end
`endif

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
